// File: rtl/lsq_dcache_arbiter_pkg.sv
// Shared LSQ definitions: queue depth, memory-size encodings, arbiter states
// and the DCache address-slice widths.
package lsq_pkg;
  localparam int LSQSZ       = 16;
  localparam int LSQ_IDX_W   = $clog2(LSQSZ);
  localparam int DC_OFFSET_W = 3;
  localparam int DC_IDX_W    = 5;
  localparam int DC_TAG_W    = 8;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    WR_WAIT  = 2'd2,
    RD_DRAIN = 2'd3
  } arb_state_e;
endpackage

// File: rtl/lsq_dcache_arbiter_if.sv
// DCache request/response port shared by the LSQ arbiter (master) and the
// cache (slave).
interface lsq_dcache_arbiter_if;
  import lsq_pkg::*;

  logic                   dc_busy;
  logic                   dc_rd_en;
  logic                   dc_wr_en;
  logic [DC_OFFSET_W-1:0] dc_offset;
  logic [DC_IDX_W-1:0]    dc_idx;
  logic [DC_TAG_W-1:0]    dc_tag;
  logic [1:0]             dc_size;
  logic [63:0]            dc_wr_data;
  logic                   dc_rd_valid;
  logic [63:0]            dc_rd_data;
  logic                   dc_wr_ack;

  modport master (
    input  dc_busy, dc_rd_valid, dc_rd_data, dc_wr_ack,
    output dc_rd_en, dc_wr_en, dc_offset, dc_idx, dc_tag, dc_size, dc_wr_data
  );

  modport slave (
    output dc_busy, dc_rd_valid, dc_rd_data, dc_wr_ack,
    input  dc_rd_en, dc_wr_en, dc_offset, dc_idx, dc_tag, dc_size, dc_wr_data
  );
endinterface

// File: rtl/lsq_dcache_arbiter_age_picker.sv
// Circular first-set-bit finder: returns the first set mask bit at or after
// i_head, wrapping from N-1 back to 0. Purely combinational.
module lsq_age_picker #(
  parameter  int N = lsq_pkg::LSQSZ,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_mask,
  input  logic [W-1:0] i_head,
  output logic         o_vld,
  output logic [W-1:0] o_idx
);
  int          pos;
  logic [W-1:0] pos_w;

  // Scan from the farthest offset back toward the head so the nearest hit wins.
  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    pos   = 0;
    pos_w = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = int'(i_head) + i;
      if (pos >= N) pos = pos - N;
      pos_w = W'(pos);
      if (i_mask[pos_w]) begin
        o_vld = 1'b1;
        o_idx = pos_w;
      end
    end
  end
endmodule

// File: rtl/lsq_dcache_arbiter.sv
// Arbitrates the LSQ's single DCache port between the committed SQ head store
// and the oldest ready load, one outstanding access at a time.
module lsq_dcache_arbiter #(
  parameter  int LSQSZ  = lsq_pkg::LSQSZ,
  parameter  int STARVE = 3,
  localparam int IDX_W  = $clog2(LSQSZ)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   except,
  input  logic                   st_req,
  input  logic [63:0]            st_addr,
  input  logic [63:0]            st_data,
  input  logic [1:0]             st_size,
  output logic                   st_done,
  input  logic [IDX_W-1:0]       lq_head,
  input  logic [LSQSZ-1:0]       ld_ready,
  input  logic [LSQSZ-1:0][63:0] ld_addr,
  input  logic [LSQSZ-1:0][1:0]  ld_size,
  output logic [LSQSZ-1:0]       ld_issue,
  output logic                   ld_done,
  output logic [IDX_W-1:0]       ld_done_idx,
  output logic [63:0]            ld_data,
  lsq_dcache_arbiter_if.master   dc
);
  import lsq_pkg::*;

  localparam int STRK_W = $clog2(STARVE + 1);

  arb_state_e         r_state, w_state_nxt;
  logic [STRK_W-1:0]  r_streak;
  logic [IDX_W-1:0]   r_ld_idx;

  logic               w_ld_vld;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [63:0]        w_sel_addr;
  logic [LSQSZ-1:0]   w_issue_oh;
  logic               w_sel_en;
  logic               w_starved;
  logic               w_grant_ld;
  logic               w_grant_st;
  logic               w_ld_resp;
  logic               w_unused;

  lsq_age_picker #(.N(LSQSZ)) u_age_picker (
    .i_mask (ld_ready),
    .i_head (lq_head),
    .o_vld  (w_ld_vld),
    .o_idx  (w_pick_idx)
  );

  assign w_sel_addr = ld_addr[w_pick_idx];
  assign w_issue_oh = {{(LSQSZ-1){1'b0}}, 1'b1} << w_pick_idx;
  assign w_unused   = ^{w_sel_addr[63:16], st_addr[63:16]};

  // Selection: stores win unless they have hogged the port for STARVE grants.
  assign w_sel_en   = (r_state == IDLE) && !dc.dc_busy && !except;
  assign w_starved  = (r_streak == STRK_W'(STARVE));
  assign w_grant_ld = w_sel_en && w_ld_vld && (!st_req || w_starved);
  assign w_grant_st = w_sel_en && st_req && !w_grant_ld;

  // A response that coincides with a flush is dropped along with the load.
  assign w_ld_resp  = (r_state == RD_WAIT) && dc.dc_rd_valid && !except;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_ld)      w_state_nxt = RD_WAIT;
        else if (w_grant_st) w_state_nxt = WR_WAIT;
      end
      RD_WAIT: begin
        if (dc.dc_rd_valid)  w_state_nxt = IDLE;
        else if (except)     w_state_nxt = RD_DRAIN;
      end
      RD_DRAIN: begin
        if (dc.dc_rd_valid)  w_state_nxt = IDLE;
      end
      WR_WAIT: begin
        if (dc.dc_wr_ack)    w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant cycle -> registered request fields, strobes and issue pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_streak      <= '0;
      r_ld_idx      <= '0;
      dc.dc_rd_en   <= 1'b0;
      dc.dc_wr_en   <= 1'b0;
      dc.dc_offset  <= '0;
      dc.dc_idx     <= '0;
      dc.dc_tag     <= '0;
      dc.dc_size    <= '0;
      dc.dc_wr_data <= '0;
      ld_issue      <= '0;
      ld_done       <= 1'b0;
      ld_done_idx   <= '0;
      ld_data       <= '0;
      st_done       <= 1'b0;
    end else begin
      dc.dc_rd_en <= w_grant_ld;
      dc.dc_wr_en <= w_grant_st;
      ld_issue    <= w_grant_ld ? w_issue_oh : '0;
      ld_done     <= w_ld_resp;
      st_done     <= (r_state == WR_WAIT) && dc.dc_wr_ack;

      if (w_grant_ld) begin
        r_streak     <= '0;
        r_ld_idx     <= w_pick_idx;
        dc.dc_offset <= w_sel_addr[2:0];
        dc.dc_idx    <= w_sel_addr[7:3];
        dc.dc_tag    <= w_sel_addr[15:8];
        dc.dc_size   <= ld_size[w_pick_idx];
      end else if (w_grant_st) begin
        r_streak      <= !w_ld_vld ? '0 : (w_starved ? r_streak : r_streak + 1'b1);
        dc.dc_offset  <= st_addr[2:0];
        dc.dc_idx     <= st_addr[7:3];
        dc.dc_tag     <= st_addr[15:8];
        dc.dc_size    <= st_size;
        dc.dc_wr_data <= st_data;
      end

      if (w_ld_resp) begin
        ld_done_idx <= r_ld_idx;
        ld_data     <= dc.dc_rd_data;
      end
    end
  end
endmodule

// File: tb/tb_lsq_dcache_arbiter.sv
// Directed bench for lsq_dcache_arbiter: a cycle table plus a store-starvation
// sequence driven by a small handshake loop.
module tb_lsq_dcache_arbiter;
  logic               clock;
  logic               reset;
  logic               except;
  logic               st_req;
  logic [63:0]        st_addr;
  logic [63:0]        st_data;
  logic [1:0]         st_size;
  logic               st_done;
  logic [3:0]         lq_head;
  logic [15:0]        ld_ready;
  logic [15:0][63:0]  ld_addr;
  logic [15:0][1:0]   ld_size;
  logic [15:0]        ld_issue;
  logic               ld_done;
  logic [3:0]         ld_done_idx;
  logic [63:0]        ld_data;

  lsq_dcache_arbiter_if dcif();

  lsq_dcache_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .except      (except),
    .st_req      (st_req),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_size     (st_size),
    .st_done     (st_done),
    .lq_head     (lq_head),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_size     (ld_size),
    .ld_issue    (ld_issue),
    .ld_done     (ld_done),
    .ld_done_idx (ld_done_idx),
    .ld_data     (ld_data),
    .dc          (dcif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst, exc, st, busy, rv, wk;
    logic [3:0]  head;
    logic [15:0] ready;
    logic [63:0] rdata;
    logic        e_rd, e_wr, e_sd, e_ld;
    logic [15:0] e_iss;
    logic [3:0]  e_didx;
    logic [63:0] e_ldata;
    logic [7:0]  e_tag;
    logic [4:0]  e_idx;
    logic [2:0]  e_off;
    logic [1:0]  e_size;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs [NV];
  int n_checks;
  int n_pass;

  function automatic vec_t mk(logic [5:0] ctl, logic [3:0] head, logic [15:0] ready,
                              logic [63:0] rdata, logic [3:0] ef, logic [15:0] iss,
                              logic [3:0] didx, logic [63:0] ldata, logic [7:0] tag,
                              logic [4:0] idx, logic [2:0] off, logic [1:0] sz);
    vec_t v;
    {v.rst, v.exc, v.st, v.busy, v.rv, v.wk} = ctl;
    v.head = head; v.ready = ready; v.rdata = rdata;
    {v.e_rd, v.e_wr, v.e_sd, v.e_ld} = ef;
    v.e_iss = iss; v.e_didx = didx; v.e_ldata = ldata;
    v.e_tag = tag; v.e_idx = idx; v.e_off = off; v.e_size = sz;
    return v;
  endfunction

  function automatic vec_t zr();
    return mk(6'b0, 4'd0, 16'h0, 64'h0, 4'b0, 16'h0, 4'd0, 64'h0, 8'h0, 5'h0, 3'd0, 2'd0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [5:0] exp_wr;
  logic       got;
  logic       is_wr;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    st_addr  = 64'h1234_5678_9A00_ABCD;
    st_data  = 64'h0123_4567_89AB_CDEF;
    st_size  = 2'd3;
    for (int i = 0; i < 16; i++) begin
      ld_addr[i] = 64'hCAFE_0000_0000_0000 + 64'(i << 8) + 64'(i << 3) + 64'(i & 7);
      ld_size[i] = 2'(i);
    end

    vecs[0]  = mk(6'b100000, 4'd0,  16'h0000, 64'h0,    4'b0000, 16'h0000, 4'd0,  64'h0,    8'h00, 5'h00, 3'd0, 2'd0);
    vecs[1]  = mk(6'b000000, 4'd0,  16'h0010, 64'h0,    4'b1000, 16'h0010, 4'd0,  64'h0,    8'h04, 5'h04, 3'd4, 2'd0);
    vecs[2]  = zr();
    vecs[3]  = mk(6'b000010, 4'd0,  16'h0000, 64'hDEAD, 4'b0001, 16'h0000, 4'd4,  64'hDEAD, 8'h00, 5'h00, 3'd0, 2'd0);
    vecs[4]  = zr();
    vecs[5]  = mk(6'b000000, 4'd14, 16'h8003, 64'h0,    4'b1000, 16'h8000, 4'd0,  64'h0,    8'h0F, 5'h0F, 3'd7, 2'd3);
    vecs[6]  = mk(6'b000000, 4'd14, 16'h0003, 64'h0,    4'b0000, 16'h0000, 4'd0,  64'h0,    8'h00, 5'h00, 3'd0, 2'd0);
    vecs[7]  = mk(6'b000010, 4'd14, 16'h0003, 64'h15,   4'b0001, 16'h0000, 4'd15, 64'h15,   8'h00, 5'h00, 3'd0, 2'd0);
    vecs[8]  = mk(6'b000000, 4'd15, 16'h0003, 64'h0,    4'b1000, 16'h0001, 4'd0,  64'h0,    8'h00, 5'h00, 3'd0, 2'd0);
    vecs[9]  = mk(6'b000000, 4'd15, 16'h0002, 64'h0,    4'b0000, 16'h0000, 4'd0,  64'h0,    8'h00, 5'h00, 3'd0, 2'd0);
    vecs[10] = mk(6'b000010, 4'd15, 16'h0002, 64'h1,    4'b0001, 16'h0000, 4'd0,  64'h1,    8'h00, 5'h00, 3'd0, 2'd0);
    vecs[11] = mk(6'b001100, 4'd0,  16'h0002, 64'h0,    4'b0000, 16'h0000, 4'd0,  64'h0,    8'h00, 5'h00, 3'd0, 2'd0);
    vecs[12] = vecs[11];
    vecs[13] = mk(6'b001000, 4'd0,  16'h0002, 64'h0,    4'b0100, 16'h0000, 4'd0,  64'h0,    8'hAB, 5'h19, 3'd5, 2'd3);
    vecs[14] = mk(6'b001000, 4'd0,  16'h0000, 64'h0,    4'b0000, 16'h0000, 4'd0,  64'h0,    8'h00, 5'h00, 3'd0, 2'd0);
    vecs[15] = mk(6'b001001, 4'd0,  16'h0000, 64'h0,    4'b0010, 16'h0000, 4'd0,  64'h0,    8'h00, 5'h00, 3'd0, 2'd0);
    vecs[16] = zr();
    vecs[17] = mk(6'b010000, 4'd0,  16'h0002, 64'h0,    4'b0000, 16'h0000, 4'd0,  64'h0,    8'h00, 5'h00, 3'd0, 2'd0);
    vecs[18] = mk(6'b000000, 4'd0,  16'h0002, 64'h0,    4'b1000, 16'h0002, 4'd0,  64'h0,    8'h01, 5'h01, 3'd1, 2'd1);
    vecs[19] = mk(6'b010000, 4'd0,  16'h0000, 64'h0,    4'b0000, 16'h0000, 4'd0,  64'h0,    8'h00, 5'h00, 3'd0, 2'd0);
    vecs[20] = mk(6'b001000, 4'd0,  16'h0001, 64'h0,    4'b0000, 16'h0000, 4'd0,  64'h0,    8'h00, 5'h00, 3'd0, 2'd0);
    vecs[21] = vecs[20];
    vecs[22] = mk(6'b000010, 4'd0,  16'h0000, 64'hBAD,  4'b0000, 16'h0000, 4'd0,  64'h0,    8'h00, 5'h00, 3'd0, 2'd0);
    vecs[23] = mk(6'b000000, 4'd0,  16'h0004, 64'h0,    4'b1000, 16'h0004, 4'd0,  64'h0,    8'h02, 5'h02, 3'd2, 2'd2);
    vecs[24] = zr();
    vecs[25] = mk(6'b010010, 4'd0,  16'h0000, 64'h77,   4'b0000, 16'h0000, 4'd0,  64'h0,    8'h00, 5'h00, 3'd0, 2'd0);
    vecs[26] = mk(6'b000000, 4'd0,  16'h0008, 64'h0,    4'b1000, 16'h0008, 4'd0,  64'h0,    8'h03, 5'h03, 3'd3, 2'd3);
    vecs[27] = zr();
    vecs[28] = mk(6'b000010, 4'd0,  16'h0000, 64'h33,   4'b0001, 16'h0000, 4'd3,  64'h33,   8'h00, 5'h00, 3'd0, 2'd0);
    vecs[29] = mk(6'b000000, 4'd0,  16'h0010, 64'h0,    4'b1000, 16'h0010, 4'd0,  64'h0,    8'h04, 5'h04, 3'd4, 2'd0);
    vecs[30] = mk(6'b100000, 4'd0,  16'h0000, 64'h0,    4'b0000, 16'h0000, 4'd0,  64'h0,    8'h00, 5'h00, 3'd0, 2'd0);
    vecs[31] = mk(6'b001000, 4'd0,  16'h0000, 64'h0,    4'b0100, 16'h0000, 4'd0,  64'h0,    8'hAB, 5'h19, 3'd5, 2'd3);
    vecs[32] = zr();
    vecs[33] = mk(6'b000001, 4'd0,  16'h0000, 64'h0,    4'b0010, 16'h0000, 4'd0,  64'h0,    8'h00, 5'h00, 3'd0, 2'd0);
    vecs[34] = zr();

    for (int i = 0; i < NV; i++) begin
      reset             = vecs[i].rst;
      except            = vecs[i].exc;
      st_req            = vecs[i].st;
      dcif.dc_busy      = vecs[i].busy;
      dcif.dc_rd_valid  = vecs[i].rv;
      dcif.dc_wr_ack    = vecs[i].wk;
      lq_head           = vecs[i].head;
      ld_ready          = vecs[i].ready;
      dcif.dc_rd_data   = vecs[i].rdata;
      tick();
      chk($sformatf("row%0d dc_rd_en", i), 64'(dcif.dc_rd_en), 64'(vecs[i].e_rd));
      chk($sformatf("row%0d dc_wr_en", i), 64'(dcif.dc_wr_en), 64'(vecs[i].e_wr));
      chk($sformatf("row%0d st_done", i),  64'(st_done),       64'(vecs[i].e_sd));
      chk($sformatf("row%0d ld_done", i),  64'(ld_done),       64'(vecs[i].e_ld));
      chk($sformatf("row%0d ld_issue", i), 64'(ld_issue),      64'(vecs[i].e_iss));
      if (vecs[i].e_ld || vecs[i].rst) begin
        chk($sformatf("row%0d ld_done_idx", i), 64'(ld_done_idx), 64'(vecs[i].e_didx));
        chk($sformatf("row%0d ld_data", i),     ld_data,          vecs[i].e_ldata);
      end
      if (vecs[i].e_rd || vecs[i].e_wr || vecs[i].rst) begin
        chk($sformatf("row%0d dc_tag", i),    64'(dcif.dc_tag),    64'(vecs[i].e_tag));
        chk($sformatf("row%0d dc_idx", i),    64'(dcif.dc_idx),    64'(vecs[i].e_idx));
        chk($sformatf("row%0d dc_offset", i), 64'(dcif.dc_offset), 64'(vecs[i].e_off));
        chk($sformatf("row%0d dc_size", i),   64'(dcif.dc_size),   64'(vecs[i].e_size));
      end
      if (vecs[i].e_wr)
        chk($sformatf("row%0d dc_wr_data", i), dcif.dc_wr_data, st_data);
    end

    // Store pressure with one ready load: three stores, one load, then stores.
    exp_wr           = 6'b110111;
    reset            = 1'b0;
    except           = 1'b0;
    dcif.dc_busy     = 1'b0;
    dcif.dc_rd_valid = 1'b0;
    dcif.dc_wr_ack   = 1'b0;
    dcif.dc_rd_data  = 64'h5A5A;
    st_req           = 1'b1;
    lq_head          = 4'd0;
    ld_ready         = 16'h0001;
    for (int k = 0; k < 6; k++) begin
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        tick();
        if (dcif.dc_rd_en || dcif.dc_wr_en) got = 1'b1;
      end
      chk($sformatf("starve grant%0d seen", k), 64'(got), 64'd1);
      if (!got) continue;
      is_wr = dcif.dc_wr_en;
      chk($sformatf("starve grant%0d is_store", k), 64'(is_wr), 64'(exp_wr[k]));
      if (!is_wr) chk($sformatf("starve grant%0d ld_issue", k), 64'(ld_issue), 64'h1);
      tick();
      if (is_wr) dcif.dc_wr_ack = 1'b1;
      else       dcif.dc_rd_valid = 1'b1;
      tick();
      dcif.dc_wr_ack   = 1'b0;
      dcif.dc_rd_valid = 1'b0;
      if (is_wr) chk($sformatf("starve grant%0d st_done", k), 64'(st_done), 64'd1);
      else       chk($sformatf("starve grant%0d ld_done", k), 64'(ld_done), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
